// File: rtl/run_before_vlc_encoder.sv
// CAVLC run_before codeword emitter: walks a latched run list and streams Table 9-10 codewords.
// First codeword one cycle after start; holds the codeword stable while code_ready_i is low.
module run_before_vlc_encoder #(
  parameter int MAX_RUNS = 16,
  parameter int CODE_W   = 11
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_i,
  input  logic [4:0]                 runbefore_cnt_i,
  input  logic [MAX_RUNS-1:0][4:0]   runbefore_list_i,
  input  logic [3:0]                 total_zeros_i,
  output logic                       code_valid_o,
  input  logic                       code_ready_i,
  output logic [CODE_W-1:0]          code_bits_o,
  output logic [3:0]                 code_len_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       err_o
);

  localparam int IW = $clog2(MAX_RUNS);

  typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

  state_t            state_q, state_d;
  logic [4:0]        list_q [MAX_RUNS];
  logic [4:0]        cnt_q;
  logic [4:0]        idx_q;
  logic [3:0]        zl_q;
  logic              err_q;
  logic [4:0]        run;
  logic [CODE_W-1:0] lk_bits;
  logic [3:0]        lk_len;
  logic              lk_ok;
  logic              emit_vld;
  logic              err_set;

  assign run = list_q[idx_q[IW-1:0]];

  // Table lookup indexed by (zerosLeft, run); only consulted when run <= zerosLeft.
  always_comb begin
    lk_bits = '0;
    lk_len  = '0;
    lk_ok   = 1'b1;
    case (zl_q)
      4'd1: begin
        lk_bits = CODE_W'(5'd1 - run);
        lk_len  = 4'd1;
      end
      4'd2: begin
        case (run)
          5'd0:    begin lk_bits = CODE_W'(1); lk_len = 4'd1; end
          5'd1:    begin lk_bits = CODE_W'(1); lk_len = 4'd2; end
          default: begin lk_bits = CODE_W'(0); lk_len = 4'd2; end
        endcase
      end
      4'd3: begin
        lk_bits = CODE_W'(5'd3 - run);
        lk_len  = 4'd2;
      end
      4'd4: begin
        if (run < 5'd3) begin
          lk_bits = CODE_W'(5'd3 - run);
          lk_len  = 4'd2;
        end else begin
          lk_bits = CODE_W'(5'd4 - run);
          lk_len  = 4'd3;
        end
      end
      4'd5: begin
        if (run < 5'd2) begin
          lk_bits = CODE_W'(5'd3 - run);
          lk_len  = 4'd2;
        end else begin
          lk_bits = CODE_W'(5'd5 - run);
          lk_len  = 4'd3;
        end
      end
      4'd6: begin
        lk_len = 4'd3;
        case (run)
          5'd0:    begin lk_bits = CODE_W'(3); lk_len = 4'd2; end
          5'd1:    lk_bits = CODE_W'(0);
          5'd2:    lk_bits = CODE_W'(1);
          5'd3:    lk_bits = CODE_W'(3);
          5'd4:    lk_bits = CODE_W'(2);
          5'd5:    lk_bits = CODE_W'(5);
          default: lk_bits = CODE_W'(4);
        endcase
      end
      4'd0: lk_ok = 1'b0;
      default: begin
        if (run < 5'd7) begin
          lk_bits = CODE_W'(5'd7 - run);
          lk_len  = 4'd3;
        end else if (run <= 5'd14) begin
          lk_bits = CODE_W'(1);
          lk_len  = 4'(run - 5'd3);
        end else begin
          // run 15 has no codeword that fits the output width
          lk_ok = 1'b0;
        end
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    emit_vld = 1'b0;
    err_set  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) state_d = runbefore_cnt_i[4] ? DONE : EMIT;
      end
      EMIT: begin
        if (idx_q == cnt_q || zl_q == 4'd0) begin
          state_d = DONE;
        end else if (run > {1'b0, zl_q} || !lk_ok) begin
          err_set = 1'b1;
          state_d = DONE;
        end else begin
          emit_vld = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      zl_q    <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < MAX_RUNS; i++) list_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start_i) begin
        for (int i = 0; i < MAX_RUNS; i++) list_q[i] <= runbefore_list_i[i];
        cnt_q <= runbefore_cnt_i;
        zl_q  <= total_zeros_i;
        idx_q <= '0;
        err_q <= runbefore_cnt_i[4];
      end
      if (err_set) err_q <= 1'b1;
      if (emit_vld && code_ready_i) begin
        zl_q  <= zl_q - run[3:0];
        idx_q <= idx_q + 5'd1;
      end
    end
  end

  assign code_valid_o = emit_vld;
  assign code_bits_o  = emit_vld ? lk_bits : '0;
  assign code_len_o   = emit_vld ? lk_len : '0;
  assign busy_o       = (state_q != IDLE);
  assign done_o       = (state_q == DONE);
  assign err_o        = err_q;

endmodule

// File: tb/tb_run_before_vlc_encoder.sv
// Scoreboard bench for run_before_vlc_encoder: expected codewords queued at start, checked at handshake.
module tb_run_before_vlc_encoder;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start_i = 1'b0;
  logic [4:0]       runbefore_cnt_i = '0;
  logic [15:0][4:0] runbefore_list_i = '0;
  logic [3:0]       total_zeros_i = '0;
  logic             code_valid_o;
  logic             code_ready_i = 1'b1;
  logic [10:0]      code_bits_o;
  logic [3:0]       code_len_o;
  logic             busy_o;
  logic             done_o;
  logic             err_o;

  typedef struct packed {
    logic [10:0] bits;
    logic [3:0]  len;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          hs_cnt = 0;
  int          done_cnt = 0;
  logic        prev_stall = 1'b0;
  logic [10:0] prev_bits = '0;
  logic [3:0]  prev_len = '0;

  run_before_vlc_encoder #(.MAX_RUNS(16), .CODE_W(11)) dut (
    .clk(clk), .rst(rst), .start_i(start_i),
    .runbefore_cnt_i(runbefore_cnt_i), .runbefore_list_i(runbefore_list_i),
    .total_zeros_i(total_zeros_i), .code_valid_o(code_valid_o),
    .code_ready_i(code_ready_i), .code_bits_o(code_bits_o),
    .code_len_o(code_len_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (prev_stall) begin
        n_checks++;
        if (code_valid_o !== 1'b1 || code_bits_o !== prev_bits || code_len_o !== prev_len) begin
          n_fail++;
          $display("FAIL stall_stable: got v=%b %b/%0d, required v=1 %b/%0d",
                   code_valid_o, code_bits_o, code_len_o, prev_bits, prev_len);
        end
      end
      if (code_valid_o === 1'b1 && code_ready_i) begin
        n_checks++;
        hs_cnt++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_code: got %b/%0d, required no codeword", code_bits_o, code_len_o);
        end else begin
          e = exp_q.pop_front();
          if (code_bits_o !== e.bits || code_len_o !== e.len) begin
            n_fail++;
            $display("FAIL codeword: got %b/%0d, required %b/%0d", code_bits_o, code_len_o, e.bits, e.len);
          end
        end
      end else if (code_valid_o !== 1'b1) begin
        n_checks++;
        if (code_bits_o !== '0 || code_len_o !== '0) begin
          n_fail++;
          $display("FAIL idle_zero: got %b/%0d, required 0/0", code_bits_o, code_len_o);
        end
      end
      if (done_o === 1'b1) done_cnt++;
    end
    prev_stall = !rst && code_valid_o === 1'b1 && !code_ready_i;
    prev_bits  = code_bits_o;
    prev_len   = code_len_o;
  end

  task automatic push_exp(input logic [10:0] bits, input logic [3:0] len);
    exp_t e;
    e.bits = bits;
    e.len  = len;
    exp_q.push_back(e);
  endtask

  task automatic pulse_start(input logic [3:0] tz, input logic [4:0] cnt,
                             input logic [4:0] l0, input logic [4:0] l1,
                             input logic [4:0] l2, input logic [4:0] l3);
    @(negedge clk);
    total_zeros_i       = tz;
    runbefore_cnt_i     = cnt;
    runbefore_list_i    = '0;
    runbefore_list_i[0] = l0;
    runbefore_list_i[1] = l1;
    runbefore_list_i[2] = l2;
    runbefore_list_i[3] = l3;
    start_i             = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
  endtask

  // k = number of negedges after the start edge until done_o is seen (T+k)
  task automatic wait_done(input string name, output int k);
    bit seen = 0;
    k = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      k = i + 1;
      if (done_o === 1'b1) seen = 1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s_timeout: got no done_o in 60 cycles, required done_o", name);
    end
  endtask

  task automatic check_tail(input string name, input int d0, input int h0, input int nhs);
    repeat (3) @(negedge clk);
    n_checks++;
    if (done_cnt !== d0 + 1) begin
      n_fail++;
      $display("FAIL %s_done_once: got %0d pulses, required 1", name, done_cnt - d0);
    end
    n_checks++;
    if (hs_cnt - h0 !== nhs || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_handshakes: got %0d (left %0d), required %0d", name, hs_cnt - h0, exp_q.size(), nhs);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if (code_valid_o !== 1'b0 || code_bits_o !== '0 || code_len_o !== '0 ||
        busy_o !== 1'b0 || done_o !== 1'b0 || err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: got v=%b b=%b l=%0d busy=%b done=%b err=%b, required all 0",
               code_valid_o, code_bits_o, code_len_o, busy_o, done_o, err_o);
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_basic();
    int k, d0, h0;
    d0 = done_cnt; h0 = hs_cnt;
    push_exp(11'b10, 4'd2); push_exp(11'b1, 4'd1); push_exp(11'b00, 4'd2);
    pulse_start(4'd3, 5'd3, 5'd1, 5'd0, 5'd2, 5'd0);
    wait_done("basic", k);
    n_checks++;
    if (k !== 5) begin
      n_fail++;
      $display("FAIL basic_done_latency: got T+%0d, required T+5", k);
    end
    check_tail("basic", d0, h0, 3);
  endtask

  task automatic test_long_code();
    int k, d0, h0;
    d0 = done_cnt; h0 = hs_cnt;
    push_exp(11'b0001, 4'd4); push_exp(11'b00, 4'd2);
    pulse_start(4'd10, 5'd2, 5'd7, 5'd3, 5'd0, 5'd0);
    wait_done("long", k);
    check_tail("long", d0, h0, 2);
    d0 = done_cnt; h0 = hs_cnt;
    push_exp(11'b1, 4'd11); push_exp(11'b0, 4'd1);
    pulse_start(4'd15, 5'd2, 5'd14, 5'd1, 5'd0, 5'd0);
    wait_done("max_len", k);
    check_tail("max_len", d0, h0, 2);
  endtask

  task automatic test_zl6();
    int k, d0, h0;
    d0 = done_cnt; h0 = hs_cnt;
    push_exp(11'b000, 4'd3); push_exp(11'b11, 4'd2); push_exp(11'b000, 4'd3);
    pulse_start(4'd6, 5'd3, 5'd1, 5'd0, 5'd5, 5'd0);
    wait_done("zl6", k);
    check_tail("zl6", d0, h0, 3);
  endtask

  task automatic test_early_stop();
    int k, d0, h0;
    d0 = done_cnt; h0 = hs_cnt;
    push_exp(11'b00, 4'd2);
    pulse_start(4'd2, 5'd4, 5'd2, 5'd0, 5'd0, 5'd0);
    wait_done("early", k);
    n_checks++;
    if (k !== 3) begin
      n_fail++;
      $display("FAIL early_done_latency: got T+%0d, required T+3", k);
    end
    check_tail("early", d0, h0, 1);
  endtask

  task automatic test_backpressure();
    int k, d0, h0;
    d0 = done_cnt; h0 = hs_cnt;
    code_ready_i = 1'b0;
    push_exp(11'b10, 4'd2); push_exp(11'b1, 4'd1); push_exp(11'b00, 4'd2);
    pulse_start(4'd3, 5'd3, 5'd1, 5'd0, 5'd2, 5'd0);
    fork
      wait_done("bp", k);
      begin
        for (int c = 0; c < 3; c++) begin
          if (c == 0) begin
            @(posedge clk);
            #1 start_i = 1'b1; total_zeros_i = 4'd0; runbefore_cnt_i = 5'd0;
            @(posedge clk);
            #1 start_i = 1'b0;
            @(posedge clk);
          end else begin
            repeat (3) @(posedge clk);
          end
          #1 code_ready_i = 1'b1;
          @(posedge clk);
          #1 code_ready_i = 1'b0;
        end
      end
    join
    code_ready_i = 1'b1;
    check_tail("bp", d0, h0, 3);
  endtask

  task automatic test_error();
    int k, d0, h0;
    d0 = done_cnt; h0 = hs_cnt;
    pulse_start(4'd1, 5'd1, 5'd3, 5'd0, 5'd0, 5'd0);
    wait_done("err", k);
    n_checks++;
    if (k !== 2 || err_o !== 1'b1) begin
      n_fail++;
      $display("FAIL err_run_gt_zl: got T+%0d err=%b, required T+2 err=1", k, err_o);
    end
    check_tail("err", d0, h0, 0);
    n_checks++;
    if (err_o !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky: got err=%b, required 1", err_o);
    end
    d0 = done_cnt; h0 = hs_cnt;
    pulse_start(4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
    wait_done("clr", k);
    n_checks++;
    if (k !== 2 || err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear: got T+%0d err=%b, required T+2 err=0", k, err_o);
    end
    check_tail("clr", d0, h0, 0);
    d0 = done_cnt; h0 = hs_cnt;
    pulse_start(4'd5, 5'd16, 5'd1, 5'd0, 5'd0, 5'd0);
    wait_done("cnt16", k);
    n_checks++;
    if (k !== 1 || err_o !== 1'b1) begin
      n_fail++;
      $display("FAIL err_cnt_range: got T+%0d err=%b, required T+1 err=1", k, err_o);
    end
    check_tail("cnt16", d0, h0, 0);
  endtask

  task automatic test_mid_reset();
    int d0, k, h0;
    code_ready_i = 1'b0;
    push_exp(11'b10, 4'd2); push_exp(11'b1, 4'd1); push_exp(11'b00, 4'd2);
    pulse_start(4'd3, 5'd3, 5'd1, 5'd0, 5'd2, 5'd0);
    repeat (2) @(negedge clk);
    n_checks++;
    if (code_valid_o !== 1'b1 || busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL stalled_before_rst: got v=%b busy=%b, required 1/1", code_valid_o, busy_o);
    end
    d0 = done_cnt;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    n_checks++;
    if (code_valid_o !== 1'b0 || code_bits_o !== '0 || code_len_o !== '0 ||
        busy_o !== 1'b0 || done_o !== 1'b0 || err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rst_outputs: got v=%b b=%b l=%0d busy=%b done=%b err=%b, required all 0",
               code_valid_o, code_bits_o, code_len_o, busy_o, done_o, err_o);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (done_cnt !== d0) begin
      n_fail++;
      $display("FAIL mid_rst_no_done: got %0d pulses, required 0", done_cnt - d0);
    end
    code_ready_i = 1'b1;
    d0 = done_cnt; h0 = hs_cnt;
    push_exp(11'b0001, 4'd4); push_exp(11'b00, 4'd2);
    pulse_start(4'd10, 5'd2, 5'd7, 5'd3, 5'd0, 5'd0);
    wait_done("after_rst", k);
    check_tail("after_rst", d0, h0, 2);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_long_code();
    test_zl6();
    test_early_stop();
    test_backpressure();
    test_error();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
